// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
//   Shared types and constants for the RV32M divide/remainder unit.
//
//   Contents:
//     XLEN, DIV_ITERS, CNT_W   datapath width, iteration count, counter width
//     div_op_t                 DIV / DIVU / REM / REMU opcode encoding
//     div_state_t              divider FSM states (IDLE / CALC / FIN)
//     is_signed_op()           true for DIV and REM
//     is_rem_op()              true for REM and REMU
//     abs_val()                magnitude of an operand, optionally signed
// -----------------------------------------------------------------------------
package common_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIN  = 2'b10
    } div_state_t;

    // Bit 0 of the opcode marks the unsigned variants.
    function automatic logic is_signed_op(input div_op_t op);
        return ~op[0];
    endfunction

    // Bit 1 of the opcode selects the remainder as the result.
    function automatic logic is_rem_op(input div_op_t op);
        return op[1];
    endfunction

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which is correct once the shift-subtract loop treats it as unsigned.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                                input logic            sgn);
        return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One radix-2 restoring division step (combinational).
//   The partial remainder is shifted left by one with the next dividend bit
//   appended; if the result is not below the divisor, the divisor is
//   subtracted and the quotient bit is 1.
//
//   Ports:
//     rem       in   XLEN  current partial remainder (always < divisor)
//     dvd_msb   in   1     next dividend bit to shift in
//     divisor   in   XLEN  divisor magnitude
//     next_rem  out  XLEN  partial remainder after this step
//     q_bit     out  1     quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import common_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    // The shifted remainder needs XLEN+1 bits: with a divisor above 2^(XLEN-1)
    // the partial remainder can have its top bit set before the shift.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, dvd_msb};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = (shifted >= {1'b0, divisor});
    // Because rem < divisor on entry, both candidates fit in XLEN bits.
    assign next_rem = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/divider_unit.sv
// -----------------------------------------------------------------------------
// divider_unit
//   Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//   Radix-2 restoring shift-subtract on operand magnitudes, one quotient bit
//   per cycle, followed by sign correction. Operands are latched on start; the
//   result is returned with a one-cycle done pulse, 33 cycles after start.
//
//   Ports:
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     start      in   1      request, sampled only while busy = 0
//     op         in   2      div_op_t operation
//     a          in   XLEN   dividend (rs1)
//     b          in   XLEN   divisor (rs2)
//     busy       out  1      high whenever the FSM is not in IDLE
//     done       out  1      registered one-cycle completion pulse
//     result     out  XLEN   registered result, held until next done or rst
//     dbg_state  out  2      current FSM state, for observation only
//
//   Handshake: a request is accepted on a rising edge where start = 1 and
//   busy = 0 (including the cycle in which done = 1, since the FSM is already
//   back in IDLE). Requests while busy = 1 are dropped. done is high for
//   exactly one cycle and never together with busy.
//
//   Optional build macro:
//     DIV_EARLY_OUT_EN  divide-by-zero and signed overflow (MIN / -1) skip the
//                       iteration loop and complete one cycle after start.
//                       Without it every operation takes the full 33 cycles;
//                       results are identical either way.
// -----------------------------------------------------------------------------
module divider_unit
    import common_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  div_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output div_state_t       dbg_state
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  dvd;      // dividend magnitude, shifted out MSB first
    logic [XLEN-1:0]  dsr;      // divisor magnitude
    logic [XLEN-1:0]  rem;      // partial remainder
    logic [XLEN-1:0]  quo;      // quotient, shifted in LSB first
    logic [XLEN-1:0]  a_orig;   // raw dividend, returned by REM on divide-by-zero
    logic             rem_op;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    // ------------------------------------------------------------------
    // Operand decode at start
    // ------------------------------------------------------------------
    logic sa;
    logic sb;

    assign sa = is_signed_op(op) & a[XLEN-1];
    assign sb = is_signed_op(op) & b[XLEN-1];

`ifdef DIV_EARLY_OUT_EN
    logic b_zero;
    logic ovf;

    assign b_zero = (b == '0);
    // Only the signed ops can overflow: most-negative dividend over -1.
    assign ovf    = is_signed_op(op) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (b == {XLEN{1'b1}});
`endif

    // ------------------------------------------------------------------
    // One iteration of the shift-subtract loop
    // ------------------------------------------------------------------
    logic [XLEN-1:0] step_rem;
    logic            step_q;

    div_step u_step (
        .rem      (rem),
        .dvd_msb  (dvd[XLEN-1]),
        .divisor  (dsr),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    // ------------------------------------------------------------------
    // Final value written in FIN. Divide-by-zero takes precedence over
    // sign correction so the architectural special values come out.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    logic [XLEN-1:0] fin_val;

    assign q_signed = neg_q ? (~quo + 1'b1) : quo;
    assign r_signed = neg_r ? (~rem + 1'b1) : rem;

    always_comb begin
        fin_val = rem_op ? r_signed : q_signed;
        if (div0) begin
            fin_val = rem_op ? a_orig : {XLEN{1'b1}};
        end
    end

    // ------------------------------------------------------------------
    // FSM, datapath registers and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            quo    <= '0;
            a_orig <= '0;
            rem_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_orig <= a;
                        rem_op <= is_rem_op(op);
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        div0   <= (b == '0);
                        dvd    <= abs_val(a, is_signed_op(op));
                        dsr    <= abs_val(b, is_signed_op(op));
                        rem    <= '0;
                        quo    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (b_zero || ovf) begin
                            state <= FIN;
                        end
                        // Preload the overflow answer (quotient = MIN,
                        // remainder = 0) with no sign correction pending.
                        if (ovf) begin
                            quo   <= {1'b1, {(XLEN-1){1'b0}}};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                        end
`endif
                    end
                end

                CALC: begin
                    rem <= step_rem;
                    quo <= {quo[XLEN-2:0], step_q};
                    dvd <= {dvd[XLEN-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    // Last iteration: counter is about to wrap to zero.
                    if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                        state <= FIN;
                    end
                end

                FIN: begin
                    result <= fin_val;
                    done   <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_divider_unit.sv
// -----------------------------------------------------------------------------
// tb_divider_unit
//   Self-checking bench for divider_unit: directed cases followed by random
//   operations, each checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_divider_unit;
    import common_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic             clk;
    logic             rst;
    logic             start;
    div_op_t          op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    div_state_t       dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    divider_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Reference model: architectural RV32M results
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_div(input div_op_t o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic        [31:0] r;
        sx = x;
        sy = y;
        case (o)
            DIV: begin
                if (y == 0)                                   r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else                                          r = sx / sy;
            end
            DIVU: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM: begin
                if (y == 0)                                   r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
                else                                          r = sx % sy;
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    // Cycles from the start edge to the edge that raises done.
    function automatic int exp_latency(input div_op_t o,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
`ifdef DIV_EARLY_OUT_EN
        if (y == 0) return 1;
        if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`endif
        return 33;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard check
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (all driving/sampling 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input div_op_t o, input logic [31:0] x,
                            input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        step();
        // Inputs are free to change once the request has been sampled.
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = div_op_t'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    // Issue one operation and check latency, result and busy at done.
    task automatic run_op(input string tag, input div_op_t o,
                          input logic [31:0] x, input logic [31:0] y);
        logic [31:0] expv;
        int          lat;
        int          cyc;
        expv = ref_div(o, x, y);
        lat  = exp_latency(o, x, y);
        start_op(o, x, y);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        wait_done(0, cyc);
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_result"}, result, expv);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // After done: pulse must drop and the result must be held.
    task automatic check_hold(input string tag, input logic [31:0] expv);
        step();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, expv);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int          cyc;
        bit          seen_done;
        div_op_t     ro;
        logic [31:0] rx;
        logic [31:0] ry;

        rst   = 1'b1;
        start = 1'b0;
        op    = DIV;
        a     = '0;
        b     = '0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        step();

        // Basic unsigned
        run_op("divu_100_7", DIVU, 32'd100, 32'd7);
        check_hold("divu_100_7", 32'd14);
        run_op("remu_100_7", REMU, 32'd100, 32'd7);
        check_hold("remu_100_7", 32'd2);

        // Signed, remainder follows dividend sign
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE);
        run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE);

        // Divide by zero
        run_op("div_by0", DIV, 32'h1234_5678, 32'h0);
        run_op("rem_by0", REM, 32'h1234_5678, 32'h0);
        run_op("divu_by0", DIVU, 32'h1234_5678, 32'h0);
        run_op("remu_by0", REMU, 32'h1234_5678, 32'h0);

        // Signed overflow
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_min_max", DIVU, 32'h8000_0000, 32'hFFFF_FFFF);

        // Start while busy is ignored: original op completes on schedule
        start_op(DIVU, 32'd1000, 32'd7);
        repeat (10) step();
        op    = DIV;
        a     = 32'd5;
        b     = 32'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(11, cyc);
        check("ignored_start_latency", cyc, 33);
        check("ignored_start_result", result, 32'd142);
        check_hold("ignored_start", 32'd142);

        // Reset mid-operation at iteration 12
        start_op(DIVU, 32'd1000, 32'd7);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) seen_done = 1'b1;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", 32'(done | seen_done), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        step();
        run_op("divu_9_3", DIVU, 32'd9, 32'd3);

        // Back-to-back: second start raised in the done cycle
        run_op("b2b_first", DIVU, 32'd100, 32'd7);
        run_op("b2b_second", REMU, 32'hFFFF_FFFF, 32'd16);
        check_hold("b2b_second", 32'd15);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = div_op_t'($urandom_range(0, 3));
            rx = rand_operand();
            ry = rand_operand();
            run_op($sformatf("rand%0d", i), ro, rx, ry);
            check_hold($sformatf("rand%0d", i), ref_div(ro, rx, ry));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
